// File: rtl/spi_status_pkg.sv
// Shared constants for the SpeedSPI status register file.
// Holds the last-result codes and the register-map offsets used by the decoder.
package spi_status_pkg;

  typedef enum logic [1:0] {
    STAT_NONE  = 2'd0,
    STAT_OK    = 2'd1,
    STAT_ERR_A = 2'd2,
    STAT_ERR_B = 2'd3
  } stat_code_e;

  localparam int REG_CTRL      = 0;
  localparam int REG_PEND      = 1;
  localparam int REG_CH_BASE   = 2;
  localparam int REG_CH_STRIDE = 2;

endpackage

// File: rtl/spi_chan_status.sv
// Per-channel status: resolves success/error strobes into a sticky code,
// two saturating counters and a pending flag with W1C clear.
module spi_chan_status
  import spi_status_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             success,
  input  logic [1:0]       error,
  input  logic             pend_clr,
  input  logic             cnt_clr,
  output logic [1:0]       code,
  output logic [CNT_W-1:0] succ_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pend
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             err_ev;
  logic             ok_ev;
  logic [CNT_W-1:0] succ_base;
  logic [CNT_W-1:0] err_base;

  // Code 01 on the error lines is "ignored"; only 10/11 are real errors.
  assign err_ev = error[1];
  assign ok_ev  = success & ~err_ev;

  // A counter clear lands first, so a same-cycle event counts from zero.
  always_comb begin
    succ_base = cnt_clr ? '0 : succ_cnt;
    err_base  = cnt_clr ? '0 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code     <= STAT_NONE;
      succ_cnt <= '0;
      err_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      if (err_ev) begin
        code <= error[0] ? STAT_ERR_B : STAT_ERR_A;
      end else if (success) begin
        code <= STAT_OK;
      end
      succ_cnt <= (ok_ev && succ_base != CNT_MAX) ? succ_base + CNT_ONE : succ_base;
      err_cnt  <= (err_ev && err_base != CNT_MAX) ? err_base + CNT_ONE : err_base;
      if (err_ev || success) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_status_regs.sv
// Avalon-MM status/control register file for the SpeedSPI engines: address
// decode, IRQ enable, registered read data and the level interrupt.
module spi_status_regs
  import spi_status_pkg::*;
#(
  parameter int OFFSET   = 1,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   success,
  input  logic [2*CHANNELS-1:0] error,
  input  logic                  avs_s0_read,
  input  logic                  avs_s0_write,
  input  logic [15:0]           avs_s0_address,
  input  logic [31:0]           avs_s0_writedata,
  output logic [31:0]           avs_s0_readdata,
  output logic                  irq
);

  localparam logic [15:0] OFF = 16'(OFFSET);

  logic                in_win;
  logic [15:0]         rel;
  logic [CHANNELS-1:0] ctrl;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] pend_clr;
  logic [CHANNELS-1:0] cnt_clr;
  logic                wr_ctrl;
  logic [31:0]         rd_val;
  logic [1:0]          code     [CHANNELS];
  logic [CNT_W-1:0]    succ_cnt [CHANNELS];
  logic [CNT_W-1:0]    err_cnt  [CHANNELS];
  logic                unused_wdata;

  assign in_win       = avs_s0_address >= OFF;
  assign rel          = avs_s0_address - OFF;
  assign unused_wdata = ^avs_s0_writedata[31:CHANNELS];

  // Anything outside the window decodes to nothing: reads 0, writes dropped.
  always_comb begin
    rd_val   = '0;
    pend_clr = '0;
    cnt_clr  = '0;
    wr_ctrl  = 1'b0;
    if (in_win) begin
      if (rel == 16'(REG_CTRL)) begin
        rd_val  = 32'(ctrl);
        wr_ctrl = avs_s0_write;
      end
      if (rel == 16'(REG_PEND)) begin
        rd_val = 32'(pend);
        if (avs_s0_write) pend_clr = avs_s0_writedata[CHANNELS-1:0];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (rel == 16'(REG_CH_BASE + REG_CH_STRIDE * c)) begin
          rd_val = 32'(code[c]);
        end
        if (rel == 16'(REG_CH_BASE + REG_CH_STRIDE * c + 1)) begin
          rd_val     = (32'(err_cnt[c]) << 16) | 32'(succ_cnt[c]);
          cnt_clr[c] = avs_s0_write;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl            <= '0;
      avs_s0_readdata <= '0;
      irq             <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= avs_s0_writedata[CHANNELS-1:0];
      avs_s0_readdata <= avs_s0_read ? rd_val : '0;
      irq             <= |(pend & ctrl);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    spi_chan_status #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .success  (success[g]),
      .error    (error[2*g+1 -: 2]),
      .pend_clr (pend_clr[g]),
      .cnt_clr  (cnt_clr[g]),
      .code     (code[g]),
      .succ_cnt (succ_cnt[g]),
      .err_cnt  (err_cnt[g]),
      .pend     (pend[g])
    );
  end

endmodule

// File: tb/tb_spi_status_regs.sv
// Self-checking bench for spi_status_regs: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural register model.
module tb_spi_status_regs;

  localparam int OFFSET = 1;
  localparam int CH     = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int MASK   = (1 << CH) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] success;
  logic [2*CH-1:0] error;
  logic          rd, wr;
  logic [15:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          m_ctrl, m_pend;
  int          m_code [CH];
  int          m_sc   [CH];
  int          m_ec   [CH];
  logic [31:0] m_rd;
  logic        m_irq;

  always #5 clk = ~clk;

  spi_status_regs #(.OFFSET(OFFSET), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .success          (success),
    .error            (error),
    .avs_s0_read      (rd),
    .avs_s0_write     (wr),
    .avs_s0_address   (addr),
    .avs_s0_writedata (wdata),
    .avs_s0_readdata  (rdata),
    .irq              (irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input int a);
    if (a == 0) return 32'(m_ctrl);
    if (a == 1) return 32'(m_pend);
    if (a >= 2 && a < 2 + 2*CH) begin
      if (a % 2 == 0) return 32'(m_code[(a-2)/2]);
      return 32'((m_ec[(a-3)/2] << 16) | m_sc[(a-3)/2]);
    end
    return 32'd0;
  endfunction

  task automatic model_step();
    int a, clr, set, e;
    a = int'(addr) - OFFSET;
    if (!rst_n) begin
      m_ctrl = 0; m_pend = 0; m_rd = '0; m_irq = 1'b0;
      for (int c = 0; c < CH; c++) begin m_code[c] = 0; m_sc[c] = 0; m_ec[c] = 0; end
      return;
    end
    m_irq = (m_pend & m_ctrl) != 0;
    m_rd  = rd ? m_reg(a) : 32'd0;
    clr = 0;
    if (wr) begin
      if (a == 0) m_ctrl = int'(wdata) & MASK;
      if (a == 1) clr = int'(wdata) & MASK;
      for (int c = 0; c < CH; c++)
        if (a == 3 + 2*c) begin m_sc[c] = 0; m_ec[c] = 0; end
    end
    set = 0;
    for (int c = 0; c < CH; c++) begin
      e = int'(error[2*c +: 2]);
      if (e >= 2) begin
        m_code[c] = e;
        if (m_ec[c] < CMAX) m_ec[c]++;
        set |= 1 << c;
      end else if (success[c]) begin
        m_code[c] = 1;
        if (m_sc[c] < CMAX) m_sc[c]++;
        set |= 1 << c;
      end
    end
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; success = '0; error = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_val("rdata", rdata, m_rd);
    check_val("irq", 32'(irq), 32'(m_irq));
    idle();
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    wr = 1'b1; addr = 16'(a); wdata = d;
    step();
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    rd = 1'b1; addr = 16'(a);
    step();
    d = rdata;
  endtask

  task automatic rand_inputs();
    rd      = 1'($urandom % 2);
    wr      = ($urandom % 3) == 0;
    addr    = 16'($urandom_range(0, 12));
    wdata   = $urandom;
    success = CH'($urandom) & CH'($urandom);
    error   = (($urandom % 4) == 0) ? (2*CH)'($urandom) : '0;
  endtask

  logic [31:0] d;

  initial begin
    idle();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // reset after random activity, with traffic during reset
    for (int i = 0; i < 200; i++) begin rand_inputs(); step(); end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_inputs(); step(); end
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 2 + 2*CH; a++) begin
      bus_rd(OFFSET + a, d);
      check_val("rst_reg", d, 32'd0);
    end

    // priority: success and error B together on channel 1
    success = 4'b0010; error = 8'b0000_1100;
    step();
    bus_rd(OFFSET + 4, d); check_val("prio_stat1", d, 32'd3);
    bus_rd(OFFSET + 5, d); check_val("prio_cnt1", d, 32'h0001_0000);
    bus_rd(OFFSET + 1, d); check_val("prio_pend", d, 32'h2);
    bus_wr(OFFSET + 1, 32'hF);

    // interrupt path on channel 2
    bus_wr(OFFSET + 0, 32'h4);
    error = 8'b0010_0000;
    step();
    check_val("irq_cyc1", 32'(irq), 32'd0);
    step();
    check_val("irq_cyc2", 32'(irq), 32'd1);
    bus_wr(OFFSET + 1, 32'h4);
    check_val("irq_clr1", 32'(irq), 32'd1);
    step();
    check_val("irq_clr2", 32'(irq), 32'd0);

    // W1C and success on the same bit, same cycle
    wr = 1'b1; addr = 16'(OFFSET + 1); wdata = 32'h1; success = 4'b0001;
    step();
    bus_rd(OFFSET + 1, d); check_val("w1c_race", d & 32'h1, 32'h1);

    // saturation on channel 3
    for (int i = 0; i < 20; i++) begin success = 4'b1000; step(); end
    bus_rd(OFFSET + 9, d); check_val("sat_cnt3", d, 32'h0000_000F);
    bus_wr(OFFSET + 9, 32'h0);
    bus_rd(OFFSET + 9, d); check_val("sat_clr3", d, 32'h0);

    // bus edges
    bus_rd(OFFSET - 1, d); check_val("below_win", d, 32'h0);
    bus_rd(OFFSET + 2 + 2*CH, d); check_val("above_win", d, 32'h0);
    bus_rd(OFFSET + 0, d); check_val("ctrl_rd", d, 32'h4);
    step();
    check_val("rdata_idle", rdata, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst_n = ($urandom % 250) != 0;
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_status_regs.md
# spi_status_regs

Parametrised Avalon-MM status/control register file for the SpeedSPI controller, serving `CHANNELS` independent SPI engines. Per channel it holds a sticky last-result code, saturating success and error counters, and a pending-event bit. Pending bits are masked by a writable enable register to drive a single level interrupt. It sits between the SPI engines' `success`/`error` strobes and the Avalon slave `s0` at word base `OFFSET`.

## Interface
- `OFFSET`, 1: word-address base of the register window.
- `CHANNELS`, 4: number of SPI engines, 1..16.
- `CNT_W`, 16: width of each event counter, 1..16.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `success` in CHANNELS: per-channel one-cycle transfer-complete strobe.
- `error` in 2*CHANNELS: per-channel error code, bits [2c+1:2c]. Encoding: 00 none, 01 ignored, 10 error A, 11 error B.
- `avs_s0_read` in 1: Avalon read strobe.
- `avs_s0_write` in 1: Avalon write strobe.
- `avs_s0_address` in 16: word address.
- `avs_s0_writedata` in 32: write data.
- `avs_s0_readdata` out 32: registered read data.
- `irq` out 1: level interrupt, registered.

## Operation
- Register map, with A = address − OFFSET:
  - A=0, CTRL (RW): bits [CHANNELS-1:0] irq enable. Other bits read 0.
  - A=1, PEND (R/W1C): bit c is the channel c pending flag.
  - A=2+2c, STAT_c (RO): [7:0] last code. 0 none, 1 success, 2 error A, 3 error B.
  - A=3+2c, CNT_c: [CNT_W-1:0] success count, [16+CNT_W-1:16] error count. Any write clears both counters.
- Event resolution per channel per cycle, highest priority first: error=11 → code 3; error=10 → code 2; success → code 1. No event leaves the code unchanged.
- Only one code is latched per channel per cycle. A success strobe in the same cycle as an error event:
  - does not increment the success count;
  - the error count increments by 1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Any resolved event sets PEND[c].
- A W1C write and an event in the same cycle on the same bit: the event wins and the bit stays 1.
- CNT_c write and an event in the same cycle: the counter becomes 0, then the event is applied, so it reads 1 if incremented.
- `irq` = |(PEND & CTRL), registered.
- Reads are side-effect free. Unmapped addresses (A ≥ 2+2·CHANNELS, or address < OFFSET):
  - read 0;
  - writes to them are ignored.
- Read and write asserted together: the write is applied and the read returns the pre-write value.

## Timing
- Reset (`rst_n`=0 at a clk edge) clears all of the following; reset dominates any event or bus access in the same cycle:
  - CTRL, PEND, all codes and counters;
  - `avs_s0_readdata`;
  - `irq`.
- Read latency is fixed at 1 cycle. `avs_s0_readdata` is valid on the cycle after `avs_s0_read`, and is 0 on every cycle not following a read. No waitrequest.
- A read returns register state from before any same-edge event update.
- Event to STAT/CNT/PEND visible: 1 cycle after the strobe edge.
- Event to `irq`: 2 cycles.
- CTRL or PEND write to `irq` change: 2 cycles.
- Strobes are sampled every cycle. A strobe held for N cycles counts N events.

## Structure
- Package `spi_status_pkg` holds:
  - code constants STAT_NONE/OK/ERR_A/ERR_B;
  - register offsets REG_CTRL=0, REG_PEND=1, REG_CH_BASE=2, REG_CH_STRIDE=2.
- Sub-module `spi_chan_status`, instantiated CHANNELS times via generate, contains:
  - event resolution;
  - code register;
  - two saturating counters;
  - pending flag, with W1C and set inputs.
- The top level holds address decode, CTRL, the readdata mux/register, and `irq`.

## Test plan
- Reset: assert `rst_n`=0 for 2 cycles after random activity. Required response:
  - every register reads 0;
  - `irq`=0;
  - `avs_s0_readdata`=0.
- Priority: channel 1 receives success=1 and error=11 in the same cycle. Required response:
  - STAT_1 = 3;
  - CNT_1 = 0x0001_0000;
  - PEND = 0x2.
- Interrupt path:
  - write CTRL=0x4, then pulse error=10 on channel 2; `irq` rises exactly 2 cycles after the strobe.
  - write PEND=0x4; `irq` falls 2 cycles later.
- W1C race: write PEND=0x1 in the same cycle as success on channel 0. Required response: PEND bit 0 reads 1.
- Saturation: with CNT_W=4, pulse success 20 times on channel 3. Required response:
  - CNT_3 = 0x0000_000F;
  - a write to CNT_3 then gives 0.
- Bus edges:
  - read at OFFSET−1 returns 0;
  - read at OFFSET+2+2·CHANNELS returns 0;
  - readdata returns to 0 one cycle after a valid read.
